// File: rtl/transpose_engine.sv
// Streams a ROWS x COLS matrix from a read-port memory into a write-port memory,
// either transposed or straight-copied, under a start/busy/done handshake.
module transpose_engine #(
    parameter  int WIDTH  = 32,
    parameter  int ROWS   = 16,
    parameter  int COLS   = 16,
    parameter  int RD_LAT = 1,
    localparam int ADDR_W = ((ROWS * COLS) > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              A_rd_en,
    output logic [ADDR_W-1:0] A_rd_addr,
    input  logic [WIDTH-1:0]  A_rd_data,
    output logic              B_wr_en,
    output logic [ADDR_W-1:0] B_wr_addr,
    output logic [WIDTH-1:0]  B_wr_data
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DR_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [ROW_W-1:0]  row_r, row_nxt_s;
    logic [COL_W-1:0]  col_r, col_nxt_s;
    logic [ADDR_W-1:0] rd_addr_r, rd_addr_nxt_s;
    logic [ADDR_W-1:0] dst_addr_r, dst_addr_nxt_s;
    logic [DR_W-1:0]   drain_r, drain_nxt_s;
    logic              mode_r, mode_nxt_s;
    logic              rd_en_r, busy_r, done_r;
    logic              col_last_s, last_s;
    logic [RD_LAT-1:0] vld_pipe_r;
    logic [ADDR_W-1:0] addr_pipe_r [RD_LAT];

    assign col_last_s = (col_r == COL_W'(COLS - 1));
    assign last_s     = col_last_s && (row_r == ROW_W'(ROWS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, counter and address-generation logic.
    always_comb begin
        state_nxt_s    = state_r;
        row_nxt_s      = row_r;
        col_nxt_s      = col_r;
        rd_addr_nxt_s  = rd_addr_r;
        dst_addr_nxt_s = dst_addr_r;
        drain_nxt_s    = drain_r;
        mode_nxt_s     = mode_r;
        case (state_r)
            IDLE: begin
                row_nxt_s      = {ROW_W{1'b0}};
                col_nxt_s      = {COL_W{1'b0}};
                rd_addr_nxt_s  = {ADDR_W{1'b0}};
                dst_addr_nxt_s = {ADDR_W{1'b0}};
                drain_nxt_s    = {DR_W{1'b0}};
                if (start) begin
                    state_nxt_s = RUN;
                    mode_nxt_s  = mode;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s    = DRAIN;
                    row_nxt_s      = {ROW_W{1'b0}};
                    col_nxt_s      = {COL_W{1'b0}};
                    rd_addr_nxt_s  = {ADDR_W{1'b0}};
                    dst_addr_nxt_s = {ADDR_W{1'b0}};
                end else if (col_last_s) begin
                    // New source row: the transposed address restarts at column 0, i.e. r+1.
                    col_nxt_s      = {COL_W{1'b0}};
                    row_nxt_s      = row_r + ROW_W'(1);
                    rd_addr_nxt_s  = rd_addr_r + ADDR_W'(1);
                    dst_addr_nxt_s = mode_r ? (rd_addr_r + ADDR_W'(1))
                                            : (ADDR_W'(row_r) + ADDR_W'(1));
                end else begin
                    col_nxt_s      = col_r + COL_W'(1);
                    rd_addr_nxt_s  = rd_addr_r + ADDR_W'(1);
                    dst_addr_nxt_s = mode_r ? (rd_addr_r + ADDR_W'(1))
                                            : (dst_addr_r + ADDR_W'(ROWS));
                end
            end
            DRAIN: begin
                if (drain_r == DR_W'(RD_LAT - 1)) begin
                    state_nxt_s = DONE;
                    drain_nxt_s = {DR_W{1'b0}};
                end else begin
                    drain_nxt_s = drain_r + DR_W'(1);
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Counters, addresses and handshake outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_r      <= {ROW_W{1'b0}};
            col_r      <= {COL_W{1'b0}};
            rd_addr_r  <= {ADDR_W{1'b0}};
            dst_addr_r <= {ADDR_W{1'b0}};
            drain_r    <= {DR_W{1'b0}};
            mode_r     <= 1'b0;
            rd_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            row_r      <= row_nxt_s;
            col_r      <= col_nxt_s;
            rd_addr_r  <= rd_addr_nxt_s;
            dst_addr_r <= dst_addr_nxt_s;
            drain_r    <= drain_nxt_s;
            mode_r     <= mode_nxt_s;
            rd_en_r    <= (state_nxt_s == RUN);
            busy_r     <= (state_nxt_s == RUN) || (state_nxt_s == DRAIN);
            done_r     <= (state_nxt_s == DONE);
        end
    end

    // Valid/address delay line aligning each write with its read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe_r <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                addr_pipe_r[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            vld_pipe_r[0]  <= rd_en_r;
            addr_pipe_r[0] <= dst_addr_r;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_r[i]  <= vld_pipe_r[i-1];
                addr_pipe_r[i] <= addr_pipe_r[i-1];
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign A_rd_en   = rd_en_r;
    assign A_rd_addr = rd_addr_r;
    assign B_wr_en   = vld_pipe_r[RD_LAT-1];
    assign B_wr_addr = addr_pipe_r[RD_LAT-1];
    assign B_wr_data = B_wr_en ? A_rd_data : {WIDTH{1'b0}};

endmodule

// File: tb/tb_transpose_engine.sv
// Self-checking bench for transpose_engine: four parameter sets, table-driven
// launches, randomized launches against a reference model, and corner sequences.
module tb_transpose_engine;

    localparam int NI = 4;
    localparam int R_P [NI] = '{16, 4, 16, 1};
    localparam int C_P [NI] = '{16, 8, 16, 1};
    localparam int L_P [NI] = '{1, 1, 3, 2};
    localparam int F_IDX = 0;
    localparam int F_XOR = 1;
    localparam int F_RND = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [NI-1:0] start_s, mode_s, busy_s, done_s, rd_en_s, wr_en_s;
    logic [31:0] rd_data_s [NI];
    logic [31:0] wr_data_s [NI];
    logic [31:0] rd_addr_s [NI];
    logic [31:0] wr_addr_s [NI];
    logic [7:0] a0_ra, a0_wa, a2_ra, a2_wa;
    logic [4:0] a1_ra, a1_wa;
    logic [0:0] a3_ra, a3_wa;

    logic [31:0] amem  [NI][256];
    logic [31:0] dpipe [NI][4];
    logic [31:0] bmem  [256];

    int cyc = 0;
    int t0 = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] data;
    } wr_rec_t;
    wr_rec_t wq[$];
    int done_q[$];
    int busy_cnt, busy_first, rd_cnt;

    typedef struct {
        int          inst;
        bit          md;
        int          fill;
        int          addr;
        logic [31:0] val;
    } vec_t;
    vec_t tbl[11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    transpose_engine #(.WIDTH(32), .ROWS(16), .COLS(16), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst_n), .start(start_s[0]), .mode(mode_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .A_rd_en(rd_en_s[0]), .A_rd_addr(a0_ra), .A_rd_data(rd_data_s[0]),
        .B_wr_en(wr_en_s[0]), .B_wr_addr(a0_wa), .B_wr_data(wr_data_s[0]));
    transpose_engine #(.WIDTH(32), .ROWS(4), .COLS(8), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst_n), .start(start_s[1]), .mode(mode_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .A_rd_en(rd_en_s[1]), .A_rd_addr(a1_ra), .A_rd_data(rd_data_s[1]),
        .B_wr_en(wr_en_s[1]), .B_wr_addr(a1_wa), .B_wr_data(wr_data_s[1]));
    transpose_engine #(.WIDTH(32), .ROWS(16), .COLS(16), .RD_LAT(3)) u_dut2 (
        .clk(clk), .rst(rst_n), .start(start_s[2]), .mode(mode_s[2]), .busy(busy_s[2]),
        .done(done_s[2]), .A_rd_en(rd_en_s[2]), .A_rd_addr(a2_ra), .A_rd_data(rd_data_s[2]),
        .B_wr_en(wr_en_s[2]), .B_wr_addr(a2_wa), .B_wr_data(wr_data_s[2]));
    transpose_engine #(.WIDTH(32), .ROWS(1), .COLS(1), .RD_LAT(2)) u_dut3 (
        .clk(clk), .rst(rst_n), .start(start_s[3]), .mode(mode_s[3]), .busy(busy_s[3]),
        .done(done_s[3]), .A_rd_en(rd_en_s[3]), .A_rd_addr(a3_ra), .A_rd_data(rd_data_s[3]),
        .B_wr_en(wr_en_s[3]), .B_wr_addr(a3_wa), .B_wr_data(wr_data_s[3]));

    assign rd_addr_s[0] = 32'(a0_ra);
    assign rd_addr_s[1] = 32'(a1_ra);
    assign rd_addr_s[2] = 32'(a2_ra);
    assign rd_addr_s[3] = 32'(a3_ra);
    assign wr_addr_s[0] = 32'(a0_wa);
    assign wr_addr_s[1] = 32'(a1_wa);
    assign wr_addr_s[2] = 32'(a2_wa);
    assign wr_addr_s[3] = 32'(a3_wa);

    // Source memory models with per-instance read latency.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            for (int k = 3; k > 0; k--) dpipe[i][k] <= dpipe[i][k-1];
            dpipe[i][0] <= rd_en_s[i] ? amem[i][rd_addr_s[i][7:0]] : 32'hDEAD_BEEF;
        end
    end

    always_comb begin
        for (int i = 0; i < NI; i++) rd_data_s[i] = dpipe[i][L_P[i]-1];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic prep(input int i, input int fill);
        for (int a = 0; a < 256; a++) begin
            if (fill == F_IDX)      amem[i][a] = 32'(a);
            else if (fill == F_XOR) amem[i][a] = 32'(a) ^ 32'hA5A5_0000;
            else                    amem[i][a] = $urandom;
            bmem[a] = 32'hBAD0_0000;
        end
        wq.delete();
        done_q.delete();
        busy_cnt = 0;
        busy_first = -1;
        rd_cnt = 0;
    endtask

    // One cycle of observation at the falling edge; rel is the cycle number of the launch.
    task automatic step(input int i);
        int rel;
        @(negedge clk);
        rel = cyc - t0;
        if (wr_en_s[i]) begin
            wq.push_back('{rel, int'(wr_addr_s[i]), wr_data_s[i]});
            bmem[wr_addr_s[i][7:0]] = wr_data_s[i];
        end
        if (done_s[i]) done_q.push_back(rel);
        if (busy_s[i]) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = rel;
        end
        if (rd_en_s[i]) rd_cnt++;
    endtask

    task automatic launch_edge(input int i, input bit md);
        @(negedge clk);
        mode_s[i] = md;
        start_s[i] = 1'b1;
        t0 = cyc;
        step(i);
        start_s[i] = 1'b0;
        mode_s[i] = ~md;
    endtask

    task automatic finish_run(input int i);
        int lim = R_P[i] * C_P[i] + L_P[i] + 12;
        int left = 3;
        for (int k = 0; k < lim; k++) begin
            step(i);
            if (done_q.size() > 0) begin
                if (left == 0) break;
                left--;
            end
        end
    endtask

    // Reference: row-major reads, destination c*ROWS+r (transpose) or r*COLS+c (copy).
    task automatic verify(input int i, input bit md, input int nl);
        int nn = R_P[i] * C_P[i];
        int lat = L_P[i];
        int per = nn + lat + 2;
        int ea [256];
        logic [31:0] ed [256];
        logic [31:0] bexp [256];
        for (int r = 0; r < R_P[i]; r++) begin
            for (int c = 0; c < C_P[i]; c++) begin
                int k = r * C_P[i] + c;
                ea[k] = md ? k : c * R_P[i] + r;
                ed[k] = amem[i][k];
                bexp[ea[k]] = ed[k];
            end
        end
        chk($sformatf("u%0d write count", i), 64'(wq.size()), 64'(nl * nn));
        chk($sformatf("u%0d done count", i), 64'(done_q.size()), 64'(nl));
        for (int l = 0; l < nl; l++) begin
            if (done_q.size() > l)
                chk($sformatf("u%0d done cycle %0d", i, l), 64'(done_q[l]), 64'(l * per + nn + lat + 1));
        end
        chk($sformatf("u%0d busy cycles", i), 64'(busy_cnt), 64'(nl * (nn + lat)));
        chk($sformatf("u%0d busy first", i), 64'(busy_first), 64'(1));
        chk($sformatf("u%0d read count", i), 64'(rd_cnt), 64'(nl * nn));
        for (int j = 0; j < wq.size() && j < nl * nn; j++) begin
            int l = j / nn;
            int k = j % nn;
            chk($sformatf("u%0d wr%0d cycle", i, j), 64'(wq[j].cyc), 64'(l * per + 1 + lat + k));
            chk($sformatf("u%0d wr%0d addr", i, j), 64'(wq[j].addr), 64'(ea[k]));
            chk($sformatf("u%0d wr%0d data", i, j), 64'(wq[j].data), 64'(ed[k]));
        end
        for (int a = 0; a < nn; a++)
            chk($sformatf("u%0d B[%0d]", i, a), 64'(bmem[a]), 64'(bexp[a]));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        start_s = '0;
        mode_s = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy_s), 64'(0));
        chk("reset done", 64'(done_s), 64'(0));
        chk("reset rd_en", 64'(rd_en_s), 64'(0));
        chk("reset wr_en", 64'(wr_en_s), 64'(0));
        chk("reset rd_addr", 64'(rd_addr_s[0]), 64'(0));
        chk("reset wr_addr", 64'(wr_addr_s[0]), 64'(0));
        chk("reset wr_data", 64'(wr_data_s[0]), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0]  = '{0, 1'b0, F_IDX, 1,   32'd16};
        tbl[1]  = '{0, 1'b0, F_IDX, 16,  32'd1};
        tbl[2]  = '{0, 1'b0, F_IDX, 255, 32'd255};
        tbl[3]  = '{1, 1'b0, F_IDX, 1,   32'd8};
        tbl[4]  = '{1, 1'b0, F_IDX, 4,   32'd1};
        tbl[5]  = '{1, 1'b0, F_IDX, 9,   32'd10};
        tbl[6]  = '{0, 1'b1, F_XOR, 5,   32'hA5A5_0005};
        tbl[7]  = '{2, 1'b0, F_IDX, 17,  32'd17};
        tbl[8]  = '{2, 1'b0, F_IDX, 16,  32'd1};
        tbl[9]  = '{3, 1'b0, F_IDX, 0,   32'd0};
        tbl[10] = '{3, 1'b1, F_XOR, 0,   32'hA5A5_0000};
        for (int t = 0; t < 11; t++) begin
            prep(tbl[t].inst, tbl[t].fill);
            launch_edge(tbl[t].inst, tbl[t].md);
            finish_run(tbl[t].inst);
            verify(tbl[t].inst, tbl[t].md, 1);
            chk($sformatf("vec%0d spot B[%0d]", t, tbl[t].addr), 64'(bmem[tbl[t].addr]), 64'(tbl[t].val));
        end

        for (int n = 0; n < 6; n++) begin
            int i = int'($urandom_range(0, NI - 1));
            bit md = 1'($urandom_range(0, 1));
            prep(i, F_RND);
            launch_edge(i, md);
            finish_run(i);
            verify(i, md, 1);
        end

        // Ignored pulse during RUN, then start held high for a back-to-back relaunch.
        prep(0, F_IDX);
        launch_edge(0, 1'b0);
        for (int k = 0; k < 700; k++) begin
            int rel;
            step(0);
            rel = cyc - t0;
            if (rel == 50) start_s[0] = 1'b1;
            if (rel == 51) start_s[0] = 1'b0;
            if (rel == 200) begin
                mode_s[0] = 1'b0;
                start_s[0] = 1'b1;
            end
            if (done_q.size() == 2) begin
                start_s[0] = 1'b0;
                if (rel >= done_q[1] + 3) break;
            end
        end
        start_s[0] = 1'b0;
        verify(0, 1'b0, 2);

        // Reset in the middle of RUN.
        prep(0, F_IDX);
        launch_edge(0, 1'b0);
        for (int k = 0; k < 98; k++) step(0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 64'(busy_s[0]), 64'(0));
        chk("midrst rd_en", 64'(rd_en_s[0]), 64'(0));
        chk("midrst wr_en", 64'(wr_en_s[0]), 64'(0));
        chk("midrst wr_data", 64'(wr_data_s[0]), 64'(0));
        for (int k = 0; k < 3; k++) step(0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step(0);
        chk("midrst writes", 64'(wq.size()), 64'(98));
        chk("midrst no done", 64'(done_q.size()), 64'(0));
        chk("midrst busy cycles", 64'(busy_cnt), 64'(99));
        prep(0, F_IDX);
        launch_edge(0, 1'b0);
        finish_run(0);
        verify(0, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/transpose_engine.md
Name: transpose_engine

Overview:
- Parametrised successor to the fixed 16x16, 32-bit transpose kernels.
- Streams a ROWS x COLS matrix out of a read-port memory and writes it to a write-port memory, either transposed or straight-copied. The mode is selected per launch.
- Connects directly to the team's memref_rd/memref_wr memory models and is controlled by a start/busy/done handshake.

Parameters:
- WIDTH, 32: element width in bits.
- ROWS, 16: source matrix rows (>=1).
- COLS, 16: source matrix columns (>=1).
- RD_LAT, 1: read-data latency of the source memory in cycles (>=1).
- ADDR_W, $clog2(ROWS*COLS) (minimum 1): address width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock (single clock domain).
- rst  in  1  asynchronous, active-low reset.
- start  in  1  launch request, sampled only in IDLE.
- mode  in  1  sampled with start: 0 = transpose, 1 = copy.
- busy  out  1  high while a launch is in flight.
- done  out  1  one-cycle completion pulse.
- A_rd_en  out  1  source read enable.
- A_rd_addr  out  ADDR_W  source read address.
- A_rd_data  in  WIDTH  source read data, valid RD_LAT cycles after A_rd_en.
- B_wr_en  out  1  destination write enable.
- B_wr_addr  out  ADDR_W  destination write address.
- B_wr_data  out  WIDTH  destination write data.

Behaviour:
- Reset (rst low, asynchronous):
  - State returns to IDLE.
  - All outputs go to 0 immediately: busy, done, A_rd_en, A_rd_addr, B_wr_en, B_wr_addr, B_wr_data.
  - Row/col counters, the valid pipeline and the address pipeline clear.
  - Deassertion is synchronised by the clock; the first usable start is the first rising edge after deassertion.
- Indexing: N = ROWS*COLS. Source element (r,c) sits at address r*COLS+c.
- Read order is row-major with c innermost: r = 0..ROWS-1, c = 0..COLS-1.
- Destination address:
  - Transpose: c*ROWS+r.
  - Copy: r*COLS+c.
- Address arithmetic uses ADDR_W bits. Computed addresses never exceed N-1, so no wrap occurs.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 latches mode and moves to RUN at the next edge. Counters are zeroed.
  - RUN: A_rd_en=1 every cycle, one read per cycle for exactly N cycles.
    - c increments; on c==COLS-1 it wraps to 0 and r increments.
    - On the cycle issuing r==ROWS-1, c==COLS-1, the FSM moves to DRAIN.
  - DRAIN: A_rd_en=0 for exactly RD_LAT cycles, then moves to DONE.
  - DONE: done=1 for one cycle, then moves to IDLE.
- busy is high in RUN and DRAIN and low in IDLE and DONE.
- Write alignment:
  - The destination address and a valid bit travel through an RD_LAT-deep shift register.
  - B_wr_en is the delayed A_rd_en. B_wr_addr is the delayed destination address.
  - B_wr_data = A_rd_data, passed through combinationally in the write cycle.
  - A read issued in cycle k produces a write in cycle k+RD_LAT.
  - Exactly N writes occur per launch, one per cycle with no gaps.
- Timing:
  - With start seen at edge 0, reads occupy cycles 1..N.
  - Writes occupy cycles 1+RD_LAT..N+RD_LAT.
  - done pulses in cycle N+RD_LAT+1.
  - Total latency from start to done is N+RD_LAT+1 cycles.
- Boundary conditions:
  - start while in RUN, DRAIN or DONE is ignored; it does not queue.
  - start held high continuously relaunches on the first cycle back in IDLE, with back-to-back gap = 1 cycle (the DONE cycle).
  - mode changes after launch have no effect.
  - ROWS=1 or COLS=1: transpose addresses equal copy addresses.
  - N=1: a single read and a single write, then done at cycle 2+RD_LAT.
  - Reset mid-RUN or mid-DRAIN: writes stop immediately and no done pulse is produced. The destination is left partially written; this is defined behaviour.

Test Plan:
1. Default params (16x16, RD_LAT=1), mode=0, A[i]=i, start pulse at cycle 0 -> B[1]=16, B[16]=1, B[17]=17, B[255]=255; B_wr_en high in cycles 2..257 only; done=1 only in cycle 258; busy high in cycles 1..257.
2. ROWS=4, COLS=8, mode=0, A[i]=i -> B[1]=8, B[4]=1, B[9]=10, B[31]=31; exactly 32 writes; done in cycle 34.
3. 16x16, mode=1, A[i]=i^32'hA5A5_0000 -> B[i]=A[i] for all 256 entries; write addresses strictly ascending 0..255.
4. RD_LAT=3 with a 3-cycle memory model, 16x16, mode=0 -> same B contents as scenario 1; first write in cycle 4; done in cycle 260.
5. Second start pulse at cycle 50 during busy, then start held high -> the pulse at cycle 50 is ignored; relaunch begins in cycle 259 (the IDLE cycle after done); two done pulses 259 cycles apart.
6. rst low at cycle 100 of a 16x16 launch -> busy, A_rd_en and B_wr_en are 0 in the same cycle; no done pulse; after release, a fresh start completes normally with done at +258.
